// File: rtl/csa_acc_pkg.sv
// Shared definitions for the carry-save multi-channel accumulator:
// controller state encoding and width-derivation helpers.
package csa_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Index width for a count of items; never narrower than one bit.
    function automatic int idx_width(input int count);
        return (count <= 1) ? 1 : clog2(count);
    endfunction

    function automatic int seg_count(input int out_len, input int seg_w);
        return out_len / seg_w;
    endfunction

endpackage

// File: rtl/csa_segment_adder.sv
// One SEG_WIDTH-bit slice of the carry-propagate adder; reused for every
// segment of a resolve, one segment per cycle.
module csa_segment_adder #(
    parameter int SEG_WIDTH = 8
) (
    input  logic [SEG_WIDTH-1:0] iOpA,
    input  logic [SEG_WIDTH-1:0] iOpB,
    input  logic                 iCin,
    output logic [SEG_WIDTH-1:0] oSum,
    output logic                 oCout
);

    logic [SEG_WIDTH:0] total;

    assign total = {1'b0, iOpA} + {1'b0, iOpB} + {{SEG_WIDTH{1'b0}}, iCin};
    assign oSum  = total[SEG_WIDTH-1:0];
    assign oCout = total[SEG_WIDTH];

endmodule

// File: rtl/csa_multi_accumulator.sv
// Multi-channel carry-save accumulator with a segmented, time-multiplexed
// resolve adder. Define CSA_ACC_CLEAR_ON_READ_EN to clear a channel when it is terminated.
module csa_multi_accumulator
    import csa_acc_pkg::*;
#(
    parameter  int INPUT_LENGTH  = 16,
    parameter  int OUTPUT_LENGTH = 32,
    parameter  int CHANNELS      = 4,
    parameter  int SEG_WIDTH     = 8,
    localparam int CH_W          = idx_width(CHANNELS)
) (
    input  logic                     iClk,
    input  logic                     iRstN,
    input  logic [INPUT_LENGTH-1:0]  iA,
    input  logic [CH_W-1:0]          iCh,
    input  logic                     iSigned,
    input  logic                     iAccumulate,
    input  logic                     iTerminate,
    output logic                     oReady,
    output logic [OUTPUT_LENGTH-1:0] oRes,
    output logic [CH_W-1:0]          oResCh,
    output logic                     oDone
);

    localparam int NSEG  = seg_count(OUTPUT_LENGTH, SEG_WIDTH);
    localparam int SEG_W = idx_width(NSEG);

    state_e                   state_q, state_d;
    logic                     ready_q, ready_d;
    logic                     done_q, done_d;
    logic [OUTPUT_LENGTH-1:0] res_q, res_d;
    logic [CH_W-1:0]          res_ch_q, res_ch_d;
    logic [CH_W-1:0]          ch_lat_q, ch_lat_d;
    logic [OUTPUT_LENGTH-1:0] op_a_q, op_a_d;
    logic [OUTPUT_LENGTH-1:0] op_b_q, op_b_d;
    logic [OUTPUT_LENGTH-1:0] sum_q, sum_d;
    logic                     carry_q, carry_d;
    logic [SEG_W-1:0]         seg_q, seg_d;

    logic [OUTPUT_LENGTH-1:0] s_q [CHANNELS];
    logic [OUTPUT_LENGTH-1:0] s_d [CHANNELS];
    logic [OUTPUT_LENGTH-1:0] c_q [CHANNELS];
    logic [OUTPUT_LENGTH-1:0] c_d [CHANNELS];

    logic                     ch_valid;
    logic                     accept;
    logic                     do_acc;
    logic                     do_term;
    logic [OUTPUT_LENGTH-1:0] x_ext;
    int                       seg_base;
    logic [SEG_WIDTH-1:0]     seg_a;
    logic [SEG_WIDTH-1:0]     seg_b;
    logic [SEG_WIDTH-1:0]     seg_sum;
    logic                     seg_cout;

    assign ch_valid = (int'(iCh) < CHANNELS);
    assign accept   = ready_q && (state_q == ST_IDLE) && ch_valid;
    // Accumulate wins when both requests arrive together.
    assign do_acc   = accept && iAccumulate;
    assign do_term  = accept && iTerminate && !iAccumulate;
    assign x_ext    = iSigned ? OUTPUT_LENGTH'($signed(iA)) : OUTPUT_LENGTH'(iA);

    assign seg_base = int'(seg_q) * SEG_WIDTH;
    assign seg_a    = op_a_q[seg_base +: SEG_WIDTH];
    assign seg_b    = op_b_q[seg_base +: SEG_WIDTH];

    csa_segment_adder #(
        .SEG_WIDTH (SEG_WIDTH)
    ) u_seg_adder (
        .iOpA  (seg_a),
        .iOpB  (seg_b),
        .iCin  (carry_q),
        .oSum  (seg_sum),
        .oCout (seg_cout)
    );

    // Carry-save update: the new carry is the bitwise majority, stored
    // unshifted and weighted by two when read back.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            s_d[i] = s_q[i];
            c_d[i] = c_q[i];
            if (do_acc && (int'(iCh) == i)) begin
                s_d[i] = s_q[i] ^ x_ext ^ (c_q[i] << 1);
                c_d[i] = (s_q[i] & x_ext) | (s_q[i] & (c_q[i] << 1)) |
                         (x_ext & (c_q[i] << 1));
            end
`ifdef CSA_ACC_CLEAR_ON_READ_EN
            else if (do_term && (int'(iCh) == i)) begin
                s_d[i] = '0;
                c_d[i] = '0;
            end
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        res_d    = res_q;
        res_ch_d = res_ch_q;
        ch_lat_d = ch_lat_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        seg_d    = seg_q;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (do_term) begin
                    ready_d  = 1'b0;
                    state_d  = ST_RESOLVE;
                    ch_lat_d = iCh;
                    carry_d  = 1'b0;
                    seg_d    = '0;
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (int'(iCh) == i) begin
                            op_a_d = s_q[i];
                            op_b_d = c_q[i] << 1;
                        end
                    end
                end
            end
            ST_RESOLVE: begin
                ready_d = 1'b0;
                carry_d = seg_cout;
                seg_d   = seg_q + SEG_W'(1);
                sum_d[seg_base +: SEG_WIDTH] = seg_sum;
                if (seg_q == SEG_W'(NSEG - 1)) begin
                    res_d    = sum_d;
                    res_ch_d = ch_lat_q;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                ready_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
            res_ch_q <= '0;
            ch_lat_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            seg_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                s_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            res_q    <= res_d;
            res_ch_q <= res_ch_d;
            ch_lat_q <= ch_lat_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            seg_q    <= seg_d;
            for (int i = 0; i < CHANNELS; i++) begin
                s_q[i] <= s_d[i];
                c_q[i] <= c_d[i];
            end
        end
    end

    assign oReady = ready_q;
    assign oDone  = done_q;
    assign oRes   = res_q;
    assign oResCh = res_ch_q;

endmodule

// File: tb/tb_csa_multi_accumulator.sv
// Self-checking bench: table-driven directed vectors, hand-written corner
// sequences and random accumulate/terminate traffic against a plain-sum model.
module tb_csa_multi_accumulator;

    localparam int NSEG = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a;
    logic [1:0]  ch;
    logic        sgn, acc, term;
    logic        ready, done;
    logic [31:0] res;
    logic [1:0]  res_ch;

    logic [15:0] a3;
    logic [1:0]  ch3;
    logic        acc3, term3;
    logic        ready3, done3;
    logic [31:0] res3;
    logic [1:0]  res_ch3;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [4];

    always #5 clk = ~clk;

    csa_multi_accumulator u_dut (
        .iClk(clk), .iRstN(rst_n), .iA(a), .iCh(ch), .iSigned(sgn),
        .iAccumulate(acc), .iTerminate(term), .oReady(ready), .oRes(res),
        .oResCh(res_ch), .oDone(done)
    );

    csa_multi_accumulator #(.CHANNELS(3)) u_dut3 (
        .iClk(clk), .iRstN(rst_n), .iA(a3), .iCh(ch3), .iSigned(1'b0),
        .iAccumulate(acc3), .iTerminate(term3), .oReady(ready3), .oRes(res3),
        .oResCh(res_ch3), .oDone(done3)
    );

    typedef struct {
        int          op;    // 0 reset, 1 accumulate, 2 terminate
        logic [1:0]  ch;
        logic [15:0] a;
        bit          sgn;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ext(input logic [15:0] v, input bit s);
        return s ? 32'($signed(v)) : {16'h0000, v};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_ready", 32'(ready), 32'd0);
        check("rst_async_res", res, 32'd0);
        check("rst_async_done", 32'(done), 32'd0);
        check("rst_async_resch", 32'(res_ch), 32'd0);
        for (int i = 0; i < 4; i++) model[i] = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready_rise", 32'(ready), 32'd1);
        $display("reset applied");
    endtask

    task automatic accum(input logic [1:0] c, input logic [15:0] v, input bit s);
        @(negedge clk);
        acc = 1'b1; term = 1'b0; ch = c; a = v; sgn = s;
        @(posedge clk);
        #1;
        acc = 1'b0;
        model[c] = model[c] + ext(v, s);
        $display("accumulate ch%0d a=0x%04h signed=%0d", c, v, s);
    endtask

    // Terminate and follow the resolve edge by edge; with noise set, requests
    // are driven throughout the busy window and must all be dropped.
    task automatic terminate(input logic [1:0] c, input logic [31:0] exp, input bit noise, input string tag);
        @(negedge clk);
        check({tag, "_ready_pre"}, 32'(ready), 32'd1);
        ch = c; term = 1'b1; acc = 1'b0;
        @(posedge clk);
        #1;
        term = 1'b0;
        check({tag, "_ready_busy"}, 32'(ready), 32'd0);
        for (int k = 1; k <= NSEG + 1; k++) begin
            @(negedge clk);
            if (noise) begin
                acc = 1'b1; term = 1'b1; ch = 2'd2; a = 16'h0055; sgn = 1'b0;
            end
            @(posedge clk);
            #1;
            if (k == NSEG) begin
                check({tag, "_done"}, 32'(done), 32'd1);
                check({tag, "_res"}, res, exp);
                check({tag, "_resch"}, 32'(res_ch), 32'(c));
            end else if (k == NSEG + 1) begin
                check({tag, "_done_low"}, 32'(done), 32'd0);
                check({tag, "_ready_back"}, 32'(ready), 32'd1);
            end else begin
                check({tag, "_early_done"}, 32'(done), 32'd0);
            end
        end
        acc = 1'b0; term = 1'b0;
`ifdef CSA_ACC_CLEAR_ON_READ_EN
        model[c] = 32'd0;
`endif
        $display("terminate ch%0d res=0x%08h expected=0x%08h", c, res, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        bit seen;
        rst_n = 1'b0; a = '0; ch = '0; sgn = 1'b0; acc = 1'b0; term = 1'b0;
        a3 = '0; ch3 = '0; acc3 = 1'b0; term3 = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 32'd0;

        tbl[0]  = '{0, 2'd0, 16'h0000, 1'b0, 32'h0};
        tbl[1]  = '{1, 2'd0, 16'hFFFF, 1'b0, 32'h0};
        tbl[2]  = '{1, 2'd0, 16'hFFFF, 1'b0, 32'h0};
        tbl[3]  = '{1, 2'd0, 16'hFFFF, 1'b0, 32'h0};
        tbl[4]  = '{2, 2'd0, 16'h0000, 1'b0, 32'h0002FFFD};
        tbl[5]  = '{1, 2'd1, 16'hFFFB, 1'b1, 32'h0};
        tbl[6]  = '{1, 2'd1, 16'h0003, 1'b1, 32'h0};
        tbl[7]  = '{2, 2'd1, 16'h0000, 1'b0, 32'hFFFFFFFE};
        tbl[8]  = '{1, 2'd2, 16'd100,  1'b0, 32'h0};
        tbl[9]  = '{1, 2'd3, 16'd7,    1'b0, 32'h0};
        tbl[10] = '{1, 2'd2, 16'd20,   1'b0, 32'h0};
        tbl[11] = '{2, 2'd2, 16'h0000, 1'b0, 32'd120};
        tbl[12] = '{2, 2'd3, 16'h0000, 1'b0, 32'd7};
        tbl[13] = '{0, 2'd0, 16'h0000, 1'b0, 32'h0};
        tbl[14] = '{1, 2'd0, 16'hFFFF, 1'b1, 32'h0};
        tbl[15] = '{1, 2'd0, 16'h0001, 1'b0, 32'h0};

        for (int i = 0; i < 16; i++) begin
            case (tbl[i].op)
                0: do_reset();
                1: accum(tbl[i].ch, tbl[i].a, tbl[i].sgn);
                default: terminate(tbl[i].ch, tbl[i].exp, 1'b0, $sformatf("vec%0d", i));
            endcase
        end
        terminate(2'd0, 32'h00000000, 1'b0, "wrap");

        // Three-channel instance: channel index 3 must be ignored.
        do_reset();
        @(negedge clk);
        acc3 = 1'b1; ch3 = 2'd3; a3 = 16'd5;
        @(negedge clk);
        ch3 = 2'd0; a3 = 16'd2;
        @(negedge clk);
        acc3 = 1'b0; term3 = 1'b1; ch3 = 2'd3;
        @(negedge clk);
        term3 = 1'b0;
        pulses = 0;
        for (int k = 0; k < NSEG + 2; k++) begin
            @(posedge clk);
            #1;
            if (done3) pulses++;
        end
        check("ch3_ignored_done", 32'(pulses), 32'd0);
        check("ch3_ignored_ready", 32'(ready3), 32'd1);
        @(negedge clk);
        term3 = 1'b1; ch3 = 2'd0;
        @(negedge clk);
        term3 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (done3) seen = 1'b1;
        end
        check("ch3_term_seen", 32'(seen), 32'd1);
        check("ch3_term_res", res3, 32'd2);
        check("ch3_term_resch", 32'(res_ch3), 32'd0);
        $display("three-channel instance res=0x%08h", res3);

        // Simultaneous accumulate and terminate: only the accumulate happens.
        do_reset();
        @(negedge clk);
        acc = 1'b1; term = 1'b1; ch = 2'd0; a = 16'd5; sgn = 1'b0;
        @(posedge clk);
        #1;
        acc = 1'b0; term = 1'b0;
        model[0] = model[0] + 32'd5;
        pulses = 0;
        for (int k = 0; k < NSEG + 2; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("both_high_no_done", 32'(pulses), 32'd0);
        terminate(2'd0, model[0], 1'b0, "both_high");

        // Requests while busy are dropped.
        accum(2'd2, 16'd11, 1'b0);
        terminate(2'd0, model[0], 1'b1, "busy_noise");
        terminate(2'd2, model[2], 1'b0, "busy_ch2");

        // Reset in the middle of a resolve.
        accum(2'd1, 16'd3, 1'b0);
        terminate(2'd1, model[1], 1'b0, "pre_abort");
        accum(2'd0, 16'd5, 1'b0);
        @(negedge clk);
        term = 1'b1; ch = 2'd0;
        @(posedge clk);
        #1;
        term = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_res", res, 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) model[i] = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < NSEG + 3; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        terminate(2'd0, model[0], 1'b0, "after_abort");

        // Consecutive terminates on a channel holding 9.
        do_reset();
        accum(2'd0, 16'd9, 1'b0);
        terminate(2'd0, 32'd9, 1'b0, "dbl_first");
`ifdef CSA_ACC_CLEAR_ON_READ_EN
        terminate(2'd0, 32'd0, 1'b0, "dbl_second");
`else
        terminate(2'd0, 32'd9, 1'b0, "dbl_second");
`endif

        // Random traffic against the running-sum model.
        do_reset();
        for (int i = 0; i < 250; i++) begin
            logic [1:0] rc;
            rc = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                terminate(rc, model[rc], 1'b0, "rand");
            end else begin
                accum(rc, 16'($urandom), 1'($urandom_range(0, 1)));
            end
        end
        for (int i = 0; i < 4; i++) begin
            terminate(2'(i), model[i], 1'b0, "rand_final");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csa_multi_accumulator.md
# csa_multi_accumulator

Multi-channel, parametrised carry-save accumulator. Each channel holds a redundant sum/carry vector that absorbs one input word per cycle without carry propagation. On request, a channel is resolved to binary by a segmented carry-propagate adder. It sits beside the existing multiplier/adder datapath, giving several independent running sums (e.g. MAC lanes) with signed or unsigned inputs.

## Interface
- INPUT_LENGTH, 16, input word width
- OUTPUT_LENGTH, 32, accumulator/result width; must be ≥ INPUT_LENGTH and a multiple of SEG_WIDTH
- CHANNELS, 4, number of independent accumulators (≥1)
- SEG_WIDTH, 8, bits resolved per cycle; NSEG = OUTPUT_LENGTH/SEG_WIDTH
- iClk  in  1  clock, rising edge
- iRstN  in  1  reset, asynchronous, active-low
- iA  in  INPUT_LENGTH  operand
- iCh  in  CH_W = max(1, clog2(CHANNELS))  target channel for accumulate/terminate
- iSigned  in  1  1: sign-extend iA; 0: zero-extend
- iAccumulate  in  1  add iA into channel iCh
- iTerminate  in  1  resolve channel iCh
- oReady  out  1  requests accepted this cycle
- oRes  out  OUTPUT_LENGTH  last resolved sum
- oResCh  out  CH_W  channel of oRes
- oDone  out  1  one-cycle pulse, oRes/oResCh valid and new

## Operation
- Per channel: S and C registers, OUTPUT_LENGTH each. Value = S + (C<<1) mod 2^OUTPUT_LENGTH.
- A request is sampled only at an edge where oReady=1.
- Accumulate (IDLE): X = extended iA. Then S ← S ^ X ^ (C<<1) and C ← maj(S, X, C<<1). The carry out of the MSB is dropped. Only channel iCh changes. State stays IDLE.
- iAccumulate and iTerminate both high: accumulate only; terminate ignored.
- iCh ≥ CHANNELS: request ignored, no state change.
- Terminate (IDLE): latch channel, opA ← S, opB ← C<<1, carry ← 0. Go to RESOLVE. oReady ← 0.
- RESOLVE: segment k (k = 0..NSEG-1) is added each cycle with a registered carry. After the last segment: oRes ← sum, oResCh ← channel, oDone ← 1, state DONE.
- DONE: oDone ← 0, oReady ← 1, state IDLE.
- States: IDLE, RESOLVE (segment counter 0..NSEG-1), DONE. Any illegal encoding goes to IDLE.
- Arithmetic is modulo 2^OUTPUT_LENGTH. Signed results are read as two's complement. There is no overflow flag.

## Timing
- Reset values: oReady=0, oRes=0, oResCh=0, oDone=0, all S/C=0, state IDLE.
- oReady rises at the first rising edge after iRstN deasserts.
- An accumulate sampled at edge E is visible to a terminate sampled at E+1. Back-to-back accumulates run at 1 per cycle.
- Terminate sampled at E0:
  - oReady=0 from E0.
  - oDone=1 from E_NSEG to E_NSEG+1.
  - oReady=1 from E_NSEG+1.
  - Next request is accepted at E_NSEG+2.
  - Latency from terminate to oDone = NSEG cycles (4 by default).
- oRes/oResCh hold until the next oDone.
- iRstN asserted at any time, including mid-RESOLVE: all registers clear immediately. No oDone is produced for the aborted resolve.

## Configuration
- CSA_ACC_CLEAR_ON_READ_EN defined: at the terminate edge, the terminated channel's S and C clear to 0. The next sum starts fresh.
- Not defined: the channel keeps its state. Terminate reports a running total, and later accumulates continue from it.

## Structure
- Shared package csa_acc_pkg:
  - state encodings (IDLE/RESOLVE/DONE)
  - clog2 function, CH_W and NSEG derivation
- Sub-module csa_segment_adder: one SEG_WIDTH slice (opA slice, opB slice, carry-in → sum slice, carry-out). It is instantiated once and time-multiplexed across segments.

## Test plan
- Unsigned: ch0 accumulate 0xFFFF three times, terminate ch0 → oDone 4 cycles after the terminate edge, oRes=0x0002FFFD, oResCh=0.
- Signed: ch1 accumulate 0xFFFB (iSigned=1), then 0x0003 (iSigned=1), terminate ch1 → oRes=0xFFFFFFFE.
- Interleave: ch2+=100, ch3+=7, ch2+=20, terminate ch2 → 120; terminate ch3 → 7. Channels do not cross-talk.
- Priority/ignore cases:
  - iAccumulate=iTerminate=1 on ch0 with iA=5: no oDone; a later terminate gives 5.
  - iCh ≥ CHANNELS (CHANNELS=3, iCh=3): no effect.
  - Requests while oReady=0 are dropped.
- Wrap: ch0 accumulate 0xFFFF signed, then 0x0001 unsigned, terminate → oRes=0x00000000.
- Reset/clear:
  - iRstN pulsed mid-RESOLVE → outputs 0, no oDone; terminate ch0 afterwards → 0.
  - Two consecutive terminates of ch0 holding 9: second returns 0 with CSA_ACC_CLEAR_ON_READ_EN, 9 without.
